lc3_mem_ctrl: RTL
=================

# lc3_mem_ctrl

Parametrised memory subsystem for the LC-3 datapath. It replaces the fixed single-cycle MAR/MDR/RAM block with one that has configurable data width, address width, depth and wait-state count. It adds a ready (R) handshake to the control FSM and a debug access port on the same clock. It sits between the processor bus (MAR/MDR loads, MDR gate) and a synchronous word-addressed RAM array.

## Interface
Parameters:
- `DATA_W`, default 16: word width.
- `ADDR_W`, default 16: address width.
- `DEPTH`, default 2**ADDR_W: implemented words; must be ≤ 2**ADDR_W.
- `WAIT_CYC`, default 2: wait states per processor access, 0..15.

Ports:
- `clk`  in  1  Single clock; all state changes on the rising edge.
- `rst`  in  1  Reset, synchronous and active-low.
- `BUS`  in  DATA_W  Processor bus value.
- `ldMAR`  in  1  Load MAR from BUS[ADDR_W-1:0].
- `ldMDR`  in  1  Load MDR.
- `selMDR`  in  1  MDR source: 1 = rdata register, 0 = BUS.
- `memEN`  in  1  Processor access request.
- `memWE`  in  1  Access is a write; sampled with memEN.
- `MDROut`  out  DATA_W  MDR contents.
- `MAROut`  out  ADDR_W  MAR contents.
- `memR`  out  1  Ready pulse, one cycle.
- `memErr`  out  1  Out-of-range flag, valid with memR.
- `busy`  out  1  High whenever the state is not IDLE.
- `dbgReq`  in  1  Debug access request.
- `dbgWE`  in  1  Debug write.
- `dbgAddr`  in  ADDR_W  Debug address.
- `dbgData`  in  DATA_W  Debug write data.
- `dbgOut`  out  DATA_W  Debug read data.
- `dbgAck`  out  1  Debug completion pulse, one cycle.

## Operation
- FSM states: IDLE, WAIT, READY, DBG.
- **IDLE, request sampling.** memEN and dbgReq are sampled only in IDLE. If both are high, memEN wins and dbgReq must be held.
- **Processor access start (IDLE, memEN=1).**
  - Captures addr = MAR, we = memWE, wdata = MDR.
  - Loads cnt = WAIT_CYC and moves to WAIT.
  - Later changes to MAR or MDR do not affect the in-flight access.
- **WAIT.** If cnt == 0, perform the array access and move to READY; otherwise decrement cnt.
- **Array access at WAIT→READY.**
  - Read: rdata ← mem[addr].
  - Write: mem[addr] ← wdata and rdata ← wdata.
- **READY.**
  - memR = 1 for exactly one cycle, then return to IDLE unconditionally.
  - memEN is ignored in READY, so a held memEN does not retrigger.
  - ldMDR with selMDR=1 in READY captures the access result.
- **Debug access (IDLE, dbgReq=1, memEN=0).**
  - At the IDLE→DBG edge the access is performed: a read sets dbgOut ← mem[dbgAddr]; a write sets mem[dbgAddr] ← dbgData and dbgOut ← dbgData.
  - dbgAck = 1 in DBG for one cycle, then return to IDLE.
  - Debug accesses have no wait states.
- **Out of range (addr ≥ DEPTH).** A read returns 0 and a write is dropped. memErr = 1 during READY; a debug access gives the same data behaviour with no error flag.
- **MAR and MDR loads.** They act in any state. With selMDR=1, ldMDR outside READY loads the held rdata, i.e. the last completed processor access, or 0 after reset.
- **Reset.**
  - Reset values: state IDLE; MAR, MDR, rdata, dbgOut, cnt = 0; memR, memErr, dbgAck, busy = 0.
  - Array contents are preserved.
  - A reset during WAIT aborts the access and the write is never committed. A reset at the WAIT→READY edge takes priority over the commit.

## Timing
- With memEN sampled high at edge t (IDLE), the array access happens at edge t+WAIT_CYC+1, and memR is high between edges t+WAIT_CYC+1 and t+WAIT_CYC+2.
- Processor access occupancy is WAIT_CYC+2 cycles including READY. Back-to-back requests can start at the edge ending READY+1, i.e. from IDLE.
- Debug latency: dbgAck is high in the cycle after the sampling edge. Occupancy is 2 cycles.
- busy is registered and equals (state ≠ IDLE).
- memR, dbgAck and memErr are decoded from registered state, so there is no combinational path from the inputs.

## Structure
- Package `lc3_mem_pkg` holds:
  - the state enum (IDLE, WAIT, READY, DBG);
  - default width constants LC3_DATA_W = 16 and LC3_ADDR_W = 16;
  - the wait-counter width, 4 bits.
- Sub-module `lc3_ram_array`: a single-port synchronous RAM (DEPTH × DATA_W) with one-edge read or write. The controller muxes processor and debug addresses onto its single port.

## Test plan
- **Debug preload and processor read.** dbg write mem[0x3000]=0x1234 → dbgAck 1 cycle later. Then MAR←0x3000 and memEN=1 with WAIT_CYC=2 → memR in the 4th cycle after the sampling edge. ldMDR with selMDR=1 gives MDROut=0x1234.
- **Processor write then debug read.** MAR=0x4001, MDR=0xBEEF, memEN/memWE → memR. Then dbg read 0x4001 → dbgOut=0xBEEF. Holding memEN through READY gives no second memR.
- **Zero wait states.** WAIT_CYC=0 → memR in the 2nd cycle after the sampling edge; busy is high for exactly 2 cycles.
- **Out of range.** DEPTH=256: read 0x0100 → MDR=0, memErr=1 with memR. Write 0x0100=0xFFFF then dbg read 0x0000 → value unchanged.
- **Reset during WAIT.** mem[0x10]=0x1111; start a write of 0x2222 at 0x10, then rst=0 for one edge during WAIT. After reset: state IDLE, outputs 0, and a dbg read of 0x10 returns 0x1111.
- **Simultaneous requests.** memEN and dbgReq rise in the same IDLE cycle → processor memR first; dbgAck in the cycle after the IDLE that follows READY.

Source files
------------

// File: rtl/lc3_mem_pkg.sv
// Shared types and default sizes for the LC-3 memory controller.
package lc3_mem_pkg;

  localparam int unsigned LC3_DATA_W = 16;
  localparam int unsigned LC3_ADDR_W = 16;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2,
    DBG   = 2'd3
  } mem_state_e;

endpackage

// File: rtl/lc3_ram_array.sv
// Single-port word RAM: write commits on the clock edge, read data is
// presented for the controller to capture on that same edge.
module lc3_ram_array #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned IDX_W  = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata_c
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata_c = mem[addr];

endmodule

// File: rtl/lc3_mem_ctrl.sv
// LC-3 MAR/MDR memory controller with wait states, ready handshake and a
// debug port sharing the single RAM port.
module lc3_mem_ctrl
  import lc3_mem_pkg::*;
#(
  parameter int unsigned DATA_W   = LC3_DATA_W,
  parameter int unsigned ADDR_W   = LC3_ADDR_W,
  parameter int unsigned DEPTH    = 2**ADDR_W,
  parameter int unsigned WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] BUS,
  input  logic              ldMAR,
  input  logic              ldMDR,
  input  logic              selMDR,
  input  logic              memEN,
  input  logic              memWE,
  output logic [DATA_W-1:0] MDROut,
  output logic [ADDR_W-1:0] MAROut,
  output logic              memR,
  output logic              memErr,
  output logic              busy,
  input  logic              dbgReq,
  input  logic              dbgWE,
  input  logic [ADDR_W-1:0] dbgAddr,
  input  logic [DATA_W-1:0] dbgData,
  output logic [DATA_W-1:0] dbgOut,
  output logic              dbgAck
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

  mem_state_e        state;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic [DATA_W-1:0] rdata;
  logic              acc_we;
  logic [CNT_W-1:0]  cnt;

  logic              dbg_start;
  logic              commit;
  logic              acc_oor;
  logic              dbg_oor;
  logic              ram_we;
  logic [IDX_W-1:0]  ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  // Port arbitration: debug owns the RAM only on its IDLE->DBG edge.
  assign dbg_start = (state == IDLE) && !memEN && dbgReq;
  assign commit    = (state == WAIT) && (cnt == '0);
  assign acc_oor   = {1'b0, acc_addr} >= DEPTH_X;
  assign dbg_oor   = {1'b0, dbgAddr} >= DEPTH_X;
  assign ram_addr  = dbg_start ? IDX_W'(dbgAddr) : IDX_W'(acc_addr);
  assign ram_wdata = dbg_start ? dbgData : acc_wdata;
  // Gating with rst lets a reset on the commit edge cancel the write.
  assign ram_we    = rst && ((commit && acc_we && !acc_oor) ||
                             (dbg_start && dbgWE && !dbg_oor));

  lc3_ram_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_ram (
    .clk     (clk),
    .we      (ram_we),
    .addr    (ram_addr),
    .wdata   (ram_wdata),
    .rdata_c (ram_rdata)
  );

  // Access FSM with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      acc_addr  <= '0;
      acc_wdata <= '0;
      acc_we    <= 1'b0;
      cnt       <= '0;
      rdata     <= '0;
      dbgOut    <= '0;
      memR      <= 1'b0;
      memErr    <= 1'b0;
      dbgAck    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      memR   <= 1'b0;
      memErr <= 1'b0;
      dbgAck <= 1'b0;
      case (state)
        IDLE: begin
          if (memEN) begin
            acc_addr  <= MAROut;
            acc_wdata <= MDROut;
            acc_we    <= memWE;
            cnt       <= CNT_W'(WAIT_CYC);
            state     <= WAIT;
            busy      <= 1'b1;
          end else if (dbgReq) begin
            dbgOut <= dbgWE ? dbgData : (dbg_oor ? '0 : ram_rdata);
            dbgAck <= 1'b1;
            state  <= DBG;
            busy   <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            rdata  <= acc_we ? acc_wdata : (acc_oor ? '0 : ram_rdata);
            memR   <= 1'b1;
            memErr <= acc_oor;
            state  <= READY;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        READY: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        DBG: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // MAR/MDR loads act in every state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      MAROut <= '0;
      MDROut <= '0;
    end else begin
      if (ldMAR) MAROut <= ADDR_W'(BUS);
      if (ldMDR) MDROut <= selMDR ? rdata : BUS;
    end
  end

endmodule
